// File: rtl/cache_tag_array_lru.sv
// N-way set-associative tag store with per-set true-LRU ages, invalid-first victim choice and a swept clear.
// Optional per-line dirty tracking is enabled by defining CACHE_TAG_DIRTY_EN.
module cache_tag_array_lru #(
  parameter int WAYS    = 8,
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_op,
  input  logic                      req_write,
  input  logic [INDEX_W-1:0]        req_index,
  input  logic [TAG_W-1:0]          req_tag,
  output logic                      rsp_valid,
  output logic                      rsp_hit,
  output logic [$clog2(WAYS)-1:0]   rsp_way,
  output logic                      rsp_dirty,
  output logic [TAG_W-1:0]          rsp_victim_tag,
  output logic                      busy
);

  localparam int CW   = $clog2(WAYS);
  localparam int SETS = 1 << INDEX_W;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_FILL   = 2'b01;
  localparam logic [1:0] OP_INVAL  = 2'b10;

  typedef enum logic {ST_SWEEP, ST_IDLE} state_t;

  state_t             state_reg, state_next;
  logic [INDEX_W-1:0] ptr_reg, ptr_next;

  logic [TAG_W-1:0]   tag_mem   [SETS][WAYS];
  logic [CW-1:0]      age_mem   [SETS][WAYS];
  logic [WAYS-1:0]    valid_mem [SETS];

  logic [TAG_W-1:0]   rd_tag [WAYS];
  logic [CW-1:0]      rd_age [WAYS];
  logic [WAYS-1:0]    rd_valid;
  logic [WAYS-1:0]    hit_vec;
  logic [WAYS-1:0]    lru_vec;

  logic [TAG_W-1:0]   tag_wr [WAYS];
  logic [CW-1:0]      age_wr [WAYS];
  logic [WAYS-1:0]    valid_wr;

  logic               hit;
  logic [CW-1:0]      hit_way;
  logic [CW-1:0]      inv_way;
  logic [CW-1:0]      lru_way;
  logic [CW-1:0]      victim_way;
  logic [CW-1:0]      touch_way;
  logic [CW-1:0]      touch_age;
  logic               has_inv;

  logic               transfer;
  logic               op_lookup, op_fill, op_inval, op_rsvd;
  logic               fill_alloc;
  logic               inval_hit;
  logic               touch_en;
  logic               req_we;
  logic               sweep_we;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_SWEEP;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      ST_SWEEP: begin
        if (flush) begin
          ptr_next = '0;
        end else begin
          ptr_next = ptr_reg + 1'b1;
          if (ptr_reg == INDEX_W'(SETS - 1)) state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (flush) begin
          state_next = ST_SWEEP;
          ptr_next   = '0;
        end
      end
      default: state_next = ST_SWEEP;
    endcase
  end

  // Flush wins over a same-cycle request, so ready drops for that cycle.
  assign req_ready = (state_reg == ST_IDLE) && !flush;
  assign busy      = (state_reg == ST_SWEEP);
  assign transfer  = req_valid && req_ready;
  assign sweep_we  = (state_reg == ST_SWEEP) && !flush;

  assign op_lookup = (req_op == OP_LOOKUP);
  assign op_fill   = (req_op == OP_FILL);
  assign op_inval  = (req_op == OP_INVAL);
  assign op_rsvd   = (req_op == 2'b11);

  // ---------------- set read and match ----------------
  assign rd_valid = valid_mem[req_index];

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way_rd
      assign rd_tag[gi]  = tag_mem[req_index][gi];
      assign rd_age[gi]  = age_mem[req_index][gi];
      assign hit_vec[gi] = rd_valid[gi] && (rd_tag[gi] == req_tag);
      assign lru_vec[gi] = (rd_age[gi] == CW'(WAYS - 1));
    end
  endgenerate

  assign hit     = |hit_vec;
  assign has_inv = ~&rd_valid;

  always_comb begin
    hit_way = '0;
    inv_way = '0;
    lru_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_vec[w]) hit_way = CW'(w);
      if (lru_vec[w]) lru_way = CW'(w);
    end
    // Descending scan leaves the lowest-numbered invalid way selected.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!rd_valid[w]) inv_way = CW'(w);
    end
  end

  assign victim_way = has_inv ? inv_way : lru_way;

  assign fill_alloc = transfer && op_fill && !hit;
  assign inval_hit  = transfer && op_inval && hit;
  assign touch_en   = transfer && (op_lookup || op_fill) && (hit || op_fill);
  assign req_we     = touch_en || inval_hit;
  assign touch_way  = fill_alloc ? victim_way : hit_way;
  assign touch_age  = rd_age[touch_way];

  // ---------------- next line state ----------------
  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way_wr
      logic sel_touch, sel_alloc, sel_inval;
      assign sel_touch = touch_en && (touch_way == CW'(gi));
      assign sel_alloc = fill_alloc && (victim_way == CW'(gi));
      assign sel_inval = inval_hit && (hit_way == CW'(gi));

      always_comb begin
        age_wr[gi] = rd_age[gi];
        if (touch_en) begin
          if (sel_touch)                    age_wr[gi] = '0;
          else if (rd_age[gi] < touch_age)  age_wr[gi] = rd_age[gi] + 1'b1;
        end
      end

      assign tag_wr[gi]   = sel_alloc ? req_tag : rd_tag[gi];
      assign valid_wr[gi] = sel_alloc ? 1'b1 : (sel_inval ? 1'b0 : rd_valid[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (sweep_we) begin
      valid_mem[ptr_reg] <= '0;
      for (int w = 0; w < WAYS; w++) age_mem[ptr_reg][w] <= CW'(w);
    end else if (req_we) begin
      valid_mem[req_index] <= valid_wr;
      for (int w = 0; w < WAYS; w++) begin
        tag_mem[req_index][w] <= tag_wr[w];
        age_mem[req_index][w] <= age_wr[w];
      end
    end
  end

  // ---------------- response ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_way   <= '0;
    end else begin
      rsp_valid <= transfer;
      if (transfer) begin
        rsp_hit <= hit && !op_rsvd;
        if (hit && !op_rsvd) rsp_way <= hit_way;
        else if (fill_alloc) rsp_way <= victim_way;
        else                 rsp_way <= '0;
      end
    end
  end

`ifdef CACHE_TAG_DIRTY_EN
  logic [WAYS-1:0] dirty_mem [SETS];
  logic [WAYS-1:0] rd_dirty;
  logic [WAYS-1:0] dirty_wr;
  logic            evict_dirty;

  assign rd_dirty    = dirty_mem[req_index];
  assign evict_dirty = fill_alloc && rd_valid[victim_way] && rd_dirty[victim_way];

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_dirty
      always_comb begin
        dirty_wr[gi] = rd_dirty[gi];
        if (fill_alloc && (victim_way == CW'(gi)))
          dirty_wr[gi] = req_write;
        else if (inval_hit && (hit_way == CW'(gi)))
          dirty_wr[gi] = 1'b0;
        else if (touch_en && hit && req_write && (hit_way == CW'(gi)))
          dirty_wr[gi] = 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (sweep_we)    dirty_mem[ptr_reg]   <= '0;
    else if (req_we) dirty_mem[req_index] <= dirty_wr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_dirty      <= 1'b0;
      rsp_victim_tag <= '0;
    end else if (transfer) begin
      rsp_dirty      <= evict_dirty;
      rsp_victim_tag <= evict_dirty ? rd_tag[victim_way] : '0;
    end
  end
`else
  logic unused_write;
  assign unused_write   = req_write;
  assign rsp_dirty      = 1'b0;
  assign rsp_victim_tag = '0;
`endif

endmodule

// File: tb/tb_cache_tag_array_lru.sv
// Directed bench for cache_tag_array_lru (WAYS=4, INDEX_W=2, TAG_W=4); honours CACHE_TAG_DIRTY_EN.
module tb_cache_tag_array_lru;

`ifdef CACHE_TAG_DIRTY_EN
  localparam bit DIRTY_EN = 1'b1;
`else
  localparam bit DIRTY_EN = 1'b0;
`endif

  localparam logic [1:0] LOOKUP = 2'b00;
  localparam logic [1:0] FILL   = 2'b01;
  localparam logic [1:0] INVAL  = 2'b10;
  localparam logic [1:0] RSVD   = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic       req_write;
  logic [1:0] req_index;
  logic [3:0] req_tag;
  logic       rsp_valid;
  logic       rsp_hit;
  logic [1:0] rsp_way;
  logic       rsp_dirty;
  logic [3:0] rsp_victim_tag;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_tag_array_lru #(.WAYS(4), .INDEX_W(2), .TAG_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_write      (req_write),
    .req_index      (req_index),
    .req_tag        (req_tag),
    .rsp_valid      (rsp_valid),
    .rsp_hit        (rsp_hit),
    .rsp_way        (rsp_way),
    .rsp_dirty      (rsp_dirty),
    .rsp_victim_tag (rsp_victim_tag),
    .busy           (busy)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted request; response checked one cycle later.
  task automatic req(input string name, input logic [1:0] op, input logic wr,
                     input logic [1:0] idx, input logic [3:0] tg,
                     input logic exp_hit, input logic [1:0] exp_way);
    req_valid = 1'b1;
    req_op    = op;
    req_write = wr;
    req_index = idx;
    req_tag   = tg;
    tick();
    req_valid = 1'b0;
    $display("req %-12s op=%0d set=%0d tag=%h -> valid=%0b hit=%0b way=%0d dirty=%0b vtag=%h",
             name, op, idx, tg, rsp_valid, rsp_hit, rsp_way, rsp_dirty, rsp_victim_tag);
    chk({name, ".valid"}, 32'(rsp_valid), 32'd1);
    chk({name, ".hit"},   32'(rsp_hit),   32'(exp_hit));
    chk({name, ".way"},   32'(rsp_way),   32'(exp_way));
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_op    = LOOKUP;
    req_write = 1'b0;
    req_index = '0;
    req_tag   = '0;
    tick(); tick(); tick();

    chk("reset.busy",      32'(busy),      32'd1);
    chk("reset.ready",     32'(req_ready), 32'd0);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.rsp_hit",   32'(rsp_hit),   32'd0);
    chk("reset.rsp_way",   32'(rsp_way),   32'd0);
    chk("reset.rsp_dirty", 32'(rsp_dirty), 32'd0);

    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("sweep.busy",  32'(busy),      32'd1);
      chk("sweep.ready", 32'(req_ready), 32'd0);
      tick();
    end
    chk("idle.busy",  32'(busy),      32'd0);
    chk("idle.ready", 32'(req_ready), 32'd1);

    req("lk_s0_5", LOOKUP, 1'b0, 2'd0, 4'h5, 1'b0, 2'd0);

    // Set 1 fills in ways 0..3; ages become [3,2,1,0].
    req("fill_A", FILL, 1'b0, 2'd1, 4'hA, 1'b0, 2'd0);
    req("fill_B", FILL, 1'b0, 2'd1, 4'hB, 1'b0, 2'd1);
    req("fill_C", FILL, 1'b0, 2'd1, 4'hC, 1'b0, 2'd2);
    req("fill_D", FILL, 1'b0, 2'd1, 4'hD, 1'b0, 2'd3);
    req("lk_B",   LOOKUP, 1'b0, 2'd1, 4'hB, 1'b1, 2'd1);

    tick();
    chk("hold.valid", 32'(rsp_valid), 32'd0);
    chk("hold.hit",   32'(rsp_hit),   32'd1);
    chk("hold.way",   32'(rsp_way),   32'd1);

    // Ages [3,0,2,1] -> touch A -> [0,1,3,2]; C is LRU.
    req("lk_A",     LOOKUP, 1'b0, 2'd1, 4'hA, 1'b1, 2'd0);
    req("fill_E",   FILL,   1'b0, 2'd1, 4'hE, 1'b0, 2'd2);
    chk("fill_E.dirty", 32'(rsp_dirty), 32'd0);
    req("lk_C",     LOOKUP, 1'b0, 2'd1, 4'hC, 1'b0, 2'd0);
    req("inv_B",    INVAL,  1'b0, 2'd1, 4'hB, 1'b1, 2'd1);
    req("lk_B2",    LOOKUP, 1'b0, 2'd1, 4'hB, 1'b0, 2'd0);
    req("fill_F",   FILL,   1'b0, 2'd1, 4'hF, 1'b0, 2'd1);
    req("lk_F",     LOOKUP, 1'b0, 2'd1, 4'hF, 1'b1, 2'd1);
    req("fillhit_D", FILL,  1'b0, 2'd1, 4'hD, 1'b1, 2'd3);
    req("rsvd_E",   RSVD,   1'b0, 2'd1, 4'hE, 1'b0, 2'd0);
    req("lk_E",     LOOKUP, 1'b0, 2'd1, 4'hE, 1'b1, 2'd2);
    req("lk_s0_A",  LOOKUP, 1'b0, 2'd0, 4'hA, 1'b0, 2'd0);

    // Flush with a simultaneous request: request dropped, 4-cycle sweep.
    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = LOOKUP;
    req_index = 2'd1;
    req_tag   = 4'hF;
    #1;
    chk("flush.ready", 32'(req_ready), 32'd0);
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    $display("flush -> rsp_valid=%0b busy=%0b", rsp_valid, busy);
    chk("flush.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("flush.busy0",     32'(busy),      32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush.busy", 32'(busy), 32'd1);
    end
    tick();
    chk("flush.done_busy",  32'(busy),      32'd0);
    chk("flush.done_ready", 32'(req_ready), 32'd1);

    req("post_F", LOOKUP, 1'b0, 2'd1, 4'hF, 1'b0, 2'd0);
    req("post_E", LOOKUP, 1'b0, 2'd1, 4'hE, 1'b0, 2'd0);
    req("post_D", LOOKUP, 1'b0, 2'd1, 4'hD, 1'b0, 2'd0);
    req("post_A", LOOKUP, 1'b0, 2'd1, 4'hA, 1'b0, 2'd0);

    // Dirty eviction: set 2 filled with stores, then tag 6 evicts way 0 (tag 1).
    req("fill_1", FILL, 1'b1, 2'd2, 4'h1, 1'b0, 2'd0);
    req("fill_2", FILL, 1'b1, 2'd2, 4'h2, 1'b0, 2'd1);
    req("fill_3", FILL, 1'b1, 2'd2, 4'h3, 1'b0, 2'd2);
    req("fill_4", FILL, 1'b1, 2'd2, 4'h4, 1'b0, 2'd3);
    chk("fill_4.dirty", 32'(rsp_dirty), 32'd0);
    req("fill_6", FILL, 1'b0, 2'd2, 4'h6, 1'b0, 2'd0);
    chk("fill_6.dirty", 32'(rsp_dirty),      DIRTY_EN ? 32'd1 : 32'd0);
    chk("fill_6.vtag",  32'(rsp_victim_tag), DIRTY_EN ? 32'h1 : 32'h0);
    req("lk_1", LOOKUP, 1'b0, 2'd2, 4'h1, 1'b0, 2'd0);
    chk("lk_1.dirty", 32'(rsp_dirty), 32'd0);
    req("lk_4", LOOKUP, 1'b0, 2'd2, 4'h4, 1'b1, 2'd3);

    // Asynchronous reset clears outputs without waiting for an edge.
    rst_n = 1'b0;
    #1;
    $display("async reset -> rsp_valid=%0b hit=%0b way=%0d busy=%0b", rsp_valid, rsp_hit, rsp_way, busy);
    chk("areset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("areset.rsp_hit",   32'(rsp_hit),   32'd0);
    chk("areset.rsp_way",   32'(rsp_way),   32'd0);
    chk("areset.busy",      32'(busy),      32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
